// File: rtl/ser_frame_sched_pkg.sv
// Shared types and helpers for the round-robin frame serializer scheduler.
package ser_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int GAP_W = 4;

    // Bit counter width for a given frame width (never below one bit).
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Wrap an index in [0, 2n) back into [0, n); works for any n, not just powers of two.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/ser_frame_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request strictly after ptr, wrapping.
module rr_arbiter
    import ser_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // Scan farthest-first so the candidate nearest to ptr+1 is the one left standing.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'(rr_wrap(int'(ptr) + k, NUM_REQ));
            if (req[cand]) begin
                onehot       = '0;
                onehot[cand] = 1'b1;
                idx          = cand;
                any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ser_frame_sched.sv
// Round-robin scheduler feeding one shared LSB-first serializer with ready/valid output.
module ser_frame_sched
    import ser_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     ser_out,
    output logic                     ser_valid,
    input  logic                     ser_ready,
    output logic                     ser_first,
    output logic [IDX_W-1:0]         ser_src,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic               win_any;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic [GAP_W-1:0]   gcnt;
    logic               grant;
    logic               last_bit;
    logic               gap_end;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    assign grant    = (state == IDLE) && win_any;
    assign last_bit = (state == SHIFT) && ser_ready && (cnt == CNT_LAST);
    assign gap_end  = (state == GAP) && (gcnt == GAP_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_any)  state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (gap_end)  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Frame capture, bit/gap counters and the registered handshake pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr     <= PTR_INIT;
            shreg   <= '0;
            cnt     <= '0;
            gcnt    <= '0;
            gnt     <= '0;
            ser_src <= '0;
            done    <= 1'b0;
        end else begin
            gnt  <= grant ? win_onehot : '0;
            done <= last_bit;
            if (grant) begin
                ptr     <= win_idx;
                ser_src <= win_idx;
                shreg   <= data[win_idx*WIDTH +: WIDTH];
                cnt     <= '0;
            end else if ((state == SHIFT) && ser_ready) begin
                cnt <= last_bit ? '0 : cnt + 1'b1;
            end
            if (state == GAP) gcnt <= gcnt + 1'b1;
            else              gcnt <= '0;
        end
    end

    always_comb begin
        ser_valid = (state == SHIFT);
        ser_first = (state == SHIFT) && (cnt == '0);
        ser_out   = (state == SHIFT) ? shreg[cnt] : 1'b0;
        busy      = (state != IDLE);
    end

endmodule

// File: doc/ser_frame_sched.md
# ser_frame_sched

Round-robin scheduler that shares the 8-bit shift-register / bit-counter / bit-mux serializer between several requesters. It accepts one parallel word from the winning requester, sequences the counter-driven mux to emit the word bit-serially, LSB first, with downstream backpressure, and then re-arbitrates. It sits between the parallel producers and the serial output path, and replaces free-running `en`/`incr` strobes with handshaked sequencing.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: bits per frame, 2..16.
- `GAP_CYCLES`, default 0: extra idle cycles inserted after each frame, 0..15.

- `clk` input, 1 bit: single clock; all state is updated on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `req` input, `NUM_REQ` bits: level request, one bit per requester.
- `data` input, `NUM_REQ*WIDTH` bits: requester *i* word is at `[i*WIDTH +: WIDTH]`.
- `gnt` output, `NUM_REQ` bits: one-hot, single-cycle pulse; the word of that requester has been captured.
- `ser_out` output, 1 bit: current serial bit.
- `ser_valid` output, 1 bit: `ser_out` is valid.
- `ser_ready` input, 1 bit: downstream accepts the bit when `ser_valid && ser_ready`.
- `ser_first` output, 1 bit: high with bit 0 of each frame.
- `ser_src` output, `$clog2(NUM_REQ)` bits: index of the requester owning the current frame.
- `busy` output, 1 bit: state is not IDLE.
- `done` output, 1 bit: single-cycle pulse after the last bit of a frame is accepted.

## Operation
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer is `NUM_REQ-1`, so requester 0 has first priority.
  - Bit counter and gap counter are 0.
  - Shift register is 0.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - If `req` is nonzero at the edge, select the first set bit searching from `ptr+1` upward, modulo `NUM_REQ`.
  - Capture that requester's word into the shift register and set `ptr` to the winner.
  - Register the one-hot `gnt` and `ser_src`, clear the bit counter, and go to SHIFT.
  - If `req` is zero, stay in IDLE.
- SHIFT:
  - `ser_valid=1` and `ser_out = shreg[cnt]`, where `cnt` drives the mux select.
  - `ser_first` = (`cnt==0`).
  - On each edge with `ser_ready=1`, `cnt` increments.
  - When `cnt==WIDTH-1` and `ser_ready=1`, register `done=1`, then go to GAP if `GAP_CYCLES>0`, otherwise go to IDLE.
  - With `ser_ready=0`, all SHIFT state holds.
- GAP:
  - Count `GAP_CYCLES` cycles, then go to IDLE.
  - Requests are not arbitrated in GAP.
- Requesters hold `req` and `data` stable until `gnt` is seen.
  - A `req` still high after its `gnt` is a new request; it competes normally on the next arbitration.
  - `req` dropped before `gnt` is a withdrawn request; no error is flagged.
- The captured word is immune to later `data` changes.
- `ser_src` holds its value from grant through the end of the frame, including GAP and IDLE, until the next grant.

## Timing
- Grant latency: `req` present at IDLE edge E.
  - `gnt`, `ser_valid` and `ser_first` are high in the cycle after E.
  - `gnt` and `ser_first` coincide with bit 0.
- A frame with continuous `ser_ready` occupies exactly `WIDTH` valid cycles. Each stalled cycle adds one.
- Between frames: `ser_valid` is low for exactly `GAP_CYCLES+1` cycles. The first of these is the `done` cycle.
- `done` is asserted in the IDLE or first GAP cycle. It never coincides with `ser_valid`.
- `busy` is high from the first SHIFT cycle through the last GAP cycle. It is low in the IDLE cycle carrying `done` when `GAP_CYCLES=0`.
- Reset asserted mid-frame:
  - All outputs drop to 0 immediately (asynchronous).
  - The frame is abandoned and no `done` is issued.
  - `ptr` returns to `NUM_REQ-1`.
- Width rules:
  - The bit counter is `$clog2(WIDTH)` bits and never wraps past `WIDTH-1` inside a frame.
  - The gap counter is 4 bits.
  - The pointer increment wraps modulo `NUM_REQ`, including for non-power-of-two `NUM_REQ`.

## Structure
- Shared package `ser_sched_pkg`:
  - State enum (IDLE, SHIFT, GAP).
  - Localparams for the counter widths.
  - A function for the round-robin index wrap.
- One sub-module, `rr_arbiter`:
  - Combinational.
  - Inputs: `req`, `ptr`. Outputs: one-hot winner, winner index, `any`.
  - Instantiated once. The top holds the FSM, shift register, bit counter, gap counter and output registers.

## Test plan
- Single frame:
  - Stimulus: `req=0001`, `data[7:0]=0xA5`, `ser_ready=1`.
  - Response: `gnt=0001` for one cycle. `ser_out` = 1,0,1,0,0,1,0,1 over 8 valid cycles, with `ser_first` on the first. `done` pulses one cycle later and `ser_src=0`.
- Contention:
  - Stimulus: `req=1111` held, with distinct words 0x11, 0x22, 0x33, 0x44.
  - Response: grant order 0,1,2,3,0. Each frame carries its requester's word. Exactly 1 idle cycle between frames.
- Backpressure:
  - Stimulus: `ser_ready=0` for 3 cycles while bit 4 is presented.
  - Response: bit 4 is held stable. The frame spans 11 valid cycles and the data is unchanged.
- Gap:
  - Stimulus: `GAP_CYCLES=2`, `req=0011` held.
  - Response: 3 cycles with `ser_valid=0` between frames. `busy` is high for the two GAP cycles only.
- Reset mid-frame:
  - Stimulus: `reset` low at bit 3 of requester 2's frame; `req=0100` held through reset.
  - Response: all outputs are 0 while reset is low, with no `done`. After release, `gnt=0100` with the frame restarting at bit 0.
- Late data change:
  - Stimulus: change `data[7:0]` the cycle after `gnt`.
  - Response: the serialized bits equal the captured word.
